// File: rtl/plane_bus_writer.sv
// Queued writer for a strobed plane bus: host bytes land in a small FIFO and are
// replayed as setup / strobe / hold bus cycles, one transfer at a time.
module plane_bus_writer #(
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int EN_CYC     = 2,
    parameter int HOLD_CYC   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [D_WIDTH-1:0]            inData,
    input  logic                          inRs,
    input  logic                          inValid,
    output logic                          inReady,
    output logic [D_WIDTH-1:0]            dataOut,
    output logic                          rsOut,
    output logic                          dataEn,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

    // state  | meaning
    // IDLE   | bus quiet, waiting for a queued byte
    // SETUP  | data/rs driven, strobe low
    // STROBE | strobe high
    // HOLD   | strobe low, data/rs still held; may chain into the next SETUP
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  EN_LD    = 4'(EN_CYC - 1);
    localparam logic [3:0]  HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic           push, pop;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [D_WIDTH:0] mem [FIFO_DEPTH];
    logic [D_WIDTH:0] head;

    assign inReady = (fifoLevel != FULL_LVL);
    assign push    = inValid & inReady & reset;
    assign busy    = (state != IDLE) || (fifoLevel != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifoLevel != '0) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = EN_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    // back-to-back transfers skip IDLE to keep the period tight
                    if (fifoLevel != '0) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                        cnt_nxt   = SETUP_LD;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {inRs, inData};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoLevel <= '0;
            dataOut   <= '0;
            rsOut     <= 1'b0;
            dataEn    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                dataOut <= head[D_WIDTH-1:0];
                rsOut   <= head[D_WIDTH];
            end
            unique case ({push, pop})
                2'b10:   fifoLevel <= fifoLevel + 1'b1;
                2'b01:   fifoLevel <= fifoLevel - 1'b1;
                default: ;
            endcase
            dataEn <= (state_nxt == STROBE);
        end
    end

endmodule
